agu_issue_queue: RTL



---
 rtl/agu_pkg.sv | 26 ++
 rtl/aiq_entry.sv | 84 ++++++++
 rtl/agu_issue_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/agu_pkg.sv
// agu_pkg: shared widths, entry layout and sizing helpers for the AGU issue queue
package agu_pkg;

    localparam int PREG_W = 6;
    localparam int DATA_W = 16;
    localparam int ROB_W  = 5;
    localparam int IMM_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              rdy;
        logic [PREG_W-1:0] tag_src;
        logic [DATA_W-1:0] busA;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  tag_rob;
    } entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aiq_entry.sv
// aiq_entry: one issue-queue slot with push write, CDB tag match wakeup and clear
module aiq_entry #(
    parameter int PREG_W = agu_pkg::PREG_W,
    parameter int DATA_W = agu_pkg::DATA_W,
    parameter int IMM_W  = agu_pkg::IMM_W,
    parameter int ROB_W  = agu_pkg::ROB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              rdy_i,
    input  logic [PREG_W-1:0] tag_src_i,
    input  logic [DATA_W-1:0] busA_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [ROB_W-1:0]  tag_rob_i,
    input  logic              valid_wb_i,
    input  logic [PREG_W-1:0] tag_wb_i,
    input  logic [DATA_W-1:0] data_wb_i,
    output logic              valid_o,
    output logic              rdy_o,
    output logic [DATA_W-1:0] busA_o,
    output logic [IMM_W-1:0]  imm_o,
    output logic [ROB_W-1:0]  tag_rob_o
);

    logic              valid_q, valid_d, rdy_q, rdy_d, wake;
    logic [PREG_W-1:0] tag_src_q, tag_src_d;
    logic [DATA_W-1:0] busA_q, busA_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [ROB_W-1:0]  tag_rob_q, tag_rob_d;

    assign wake = valid_q && !rdy_q && valid_wb_i && (tag_wb_i == tag_src_q);

    // Slot update: clear beats push, push beats pop, pop beats wakeup
    always_comb begin
        valid_d   = valid_q;
        rdy_d     = rdy_q;
        tag_src_d = tag_src_q;
        busA_d    = busA_q;
        imm_d     = imm_q;
        tag_rob_d = tag_rob_q;
        if (clr_i) begin
            valid_d = 1'b0;
            rdy_d   = 1'b0;
        end else if (push_i) begin
            valid_d   = 1'b1;
            rdy_d     = rdy_i;
            tag_src_d = tag_src_i;
            busA_d    = busA_i;
            imm_d     = imm_i;
            tag_rob_d = tag_rob_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
            rdy_d   = 1'b0;
        end else if (wake) begin
            rdy_d  = 1'b1;
            busA_d = data_wb_i;
        end
    end

    // Status bits reset; payload is only ever observed behind valid/rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rdy_q     <= rdy_d;
            tag_src_q <= tag_src_d;
            busA_q    <= busA_d;
            imm_q     <= imm_d;
            tag_rob_q <= tag_rob_d;
        end
    end

    assign valid_o   = valid_q;
    assign rdy_o     = rdy_q;
    assign busA_o    = busA_q;
    assign imm_o     = imm_q;
    assign tag_rob_o = tag_rob_q;

endmodule

// File: rtl/agu_issue_queue.sv
// agu_issue_queue: in-order memory-op issue FIFO with CDB wakeup feeding the AGU
module agu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = agu_pkg::PREG_W,
    parameter int DATA_W = agu_pkg::DATA_W,
    parameter int ROB_W  = agu_pkg::ROB_W,
    parameter int IMM_W  = agu_pkg::IMM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze_back,
    input  logic                       valid_disp,
    output logic                       ready_disp,
    input  logic [ROB_W-1:0]           tag_ROB_disp,
    input  logic [IMM_W-1:0]           Imm_disp,
    input  logic [PREG_W-1:0]          tag_src_disp,
    input  logic                       rdy_src_disp,
    input  logic [DATA_W-1:0]          busA_disp,
    input  logic                       valid_wb,
    input  logic [PREG_W-1:0]          tag_wb,
    input  logic [DATA_W-1:0]          data_wb,
    output logic                       valid_agu,
    output logic [DATA_W-1:0]          busA_agu,
    output logic [IMM_W-1:0]           Imm_agu,
    output logic [ROB_W-1:0]           tag_ROB_agu,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import agu_pkg::*;

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  ent_valid, ent_rdy, push_vec, pop_vec;
    logic [DATA_W-1:0] ent_busA [DEPTH];
    logic [IMM_W-1:0]  ent_imm  [DEPTH];
    logic [ROB_W-1:0]  ent_rob  [DEPTH];
    logic              push, push_rdy;
    logic [DATA_W-1:0] push_busA;

    // No pass-through when full: a same-cycle pop does not open a slot
    assign ready_disp = !rst && !flush && (count_q < CW'(DEPTH));
    assign push       = valid_disp && ready_disp;
    assign push_rdy   = rdy_src_disp || (valid_wb && (tag_wb == tag_src_disp));
    assign push_busA  = rdy_src_disp ? busA_disp : data_wb;

    // Only the head may issue, and only on its registered ready bit
    assign valid_agu   = !rst && !flush && !freeze_back && ent_valid[head_q] && ent_rdy[head_q];
    assign busA_agu    = valid_agu ? ent_busA[head_q] : '0;
    assign Imm_agu     = valid_agu ? ent_imm[head_q]  : '0;
    assign tag_ROB_agu = valid_agu ? ent_rob[head_q]  : '0;
    assign count       = rst ? '0 : count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign push_vec[i] = push && (tail_q == PW'(i));
        assign pop_vec[i]  = valid_agu && (head_q == PW'(i));
        aiq_entry #(
            .PREG_W(PREG_W),
            .DATA_W(DATA_W),
            .IMM_W (IMM_W),
            .ROB_W (ROB_W)
        ) u_ent (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (flush),
            .push_i    (push_vec[i]),
            .pop_i     (pop_vec[i]),
            .rdy_i     (push_rdy),
            .tag_src_i (tag_src_disp),
            .busA_i    (push_busA),
            .imm_i     (Imm_disp),
            .tag_rob_i (tag_ROB_disp),
            .valid_wb_i(valid_wb),
            .tag_wb_i  (tag_wb),
            .data_wb_i (data_wb),
            .valid_o   (ent_valid[i]),
            .rdy_o     (ent_rdy[i]),
            .busA_o    (ent_busA[i]),
            .imm_o     (ent_imm[i]),
            .tag_rob_o (ent_rob[i])
        );
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        head_d  = head_q + PW'(valid_agu);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(valid_agu);
    end

    // Reset and flush both return the queue to empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
